// File: rtl/spirose_pkg.sv
// spirose_pkg
//   Shared definitions for the capture and readout sides of the frame RAM.
//   - IMAGE_WIDTH / IMAGE_HEIGHT / IMAGE_SIZE: geometry of one slice in pixels
//   - rgb565_t: one RGB565 pixel as stored in RAM
//   - reader_state_t: states of the slice reader FSM
package spirose_pkg;

  localparam int IMAGE_WIDTH  = 40;
  localparam int IMAGE_HEIGHT = 48;
  localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SLICE = 2'd1,
    ST_READ       = 2'd2,
    ST_DRAIN      = 2'd3
  } reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with fall-through read: head shows the oldest entry
//   whenever empty=0, so a consumer can take it in the same cycle.
// Ports:
//   clk, nrst   clock, asynchronous active-low reset
//   push        write push_data (ignored when full)
//   push_data   data to write
//   pop         drop the head entry (ignored when empty)
//   flush       discard all entries; has priority over push and pop
//   head        oldest entry (meaningful only when empty=0)
//   count       number of stored entries, 0..DEPTH
//   full, empty status flags derived from count
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: entries are only observed once count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_slice_reader.sv
// ram_slice_reader
//   Streams one slice (IMAGE_SIZE pixels) out of the shared frame RAM per
//   new_slice pulse, in increasing address order, towards the LED driver
//   formatter. A prefetch FIFO absorbs the fixed RAM read latency so the
//   driver may apply back-pressure at any time.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   stream_ready     capture side holds displayable slices; low aborts and flushes
//   new_slice        one-cycle pulse, start the next slice
//   ram_addr         registered read address
//   ram_read_enable  registered read request
//   ram_data         read data, valid RAM_READ_LATENCY cycles after the request
//   pixel_data       FIFO head pixel (0 when nothing is valid)
//   pixel_valid      pixel_data valid
//   pixel_ready      driver accepts pixel_data
//   slice_index      slice being read, or next to be read
//   slice_done       one-cycle pulse after the last pixel of a slice transfers
//   underrun         sticky: new_slice arrived while a slice was in progress
//   fsm_state        current FSM state for observation
//
// Handshake: a pixel transfers on every rising edge where pixel_valid and
// pixel_ready are both 1. pixel_valid never depends on pixel_ready, and once
// raised, pixel_valid and pixel_data hold until that transfer happens (only a
// stream_ready drop or reset may withdraw them).
module ram_slice_reader
  import spirose_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH   = 32,
  parameter int RAM_DATA_WIDTH   = 16,
  parameter int IMAGE_IN_RAM     = 18,
  parameter int RAM_READ_LATENCY = 2,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            stream_ready,
  input  logic                            new_slice,
  output logic [RAM_ADDR_WIDTH-1:0]       ram_addr,
  output logic                            ram_read_enable,
  input  logic [RAM_DATA_WIDTH-1:0]       ram_data,
  output logic [RAM_DATA_WIDTH-1:0]       pixel_data,
  output logic                            pixel_valid,
  input  logic                            pixel_ready,
  output logic [$clog2(IMAGE_IN_RAM)-1:0] slice_index,
  output logic                            slice_done,
  output logic                            underrun,
  output reader_state_t                   fsm_state
);

  localparam int IDX_W = $clog2(IMAGE_IN_RAM);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PIX_W = $clog2(IMAGE_SIZE + 1);
  localparam int LAT   = RAM_READ_LATENCY;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(IMAGE_IN_RAM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(IMAGE_SIZE - 1);
  localparam logic [PIX_W-1:0] PIX_ONE   = PIX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);

  reader_state_t             state;
  logic [PIX_W-1:0]          rd_cnt;      // reads issued in this slice
  logic [PIX_W-1:0]          xfer_cnt;    // pixels transferred in this slice
  logic [LAT-1:0]            lat_sr;      // request-valid bits travelling with the RAM pipeline
  logic [CNT_W-1:0]          in_flight;   // requests issued but not yet in the FIFO
  logic                      pending;     // new_slice seen while busy; start next slice at once
  logic [RAM_ADDR_WIDTH-1:0] slice_base;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [RAM_DATA_WIDTH-1:0] fifo_head;
  logic                      credit_ok;
  logic                      issue;

  assign fsm_state  = state;
  assign slice_base = RAM_ADDR_WIDTH'(slice_index) * RAM_ADDR_WIDTH'(IMAGE_SIZE);

  // Returning data is captured exactly when the matching request bit leaves
  // the latency shift register, so no RAM-side valid is needed.
  assign fifo_push = lat_sr[LAT-1];
  assign fifo_pop  = pixel_valid && pixel_ready;

  // Every outstanding request already owns a FIFO slot, so the FIFO can never
  // overflow and ram_data never needs to be refused.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, in_flight}) < DEPTH_LIM;
  assign issue     = (state == ST_READ) && credit_ok && !fifo_full;

  assign pixel_valid = !fifo_empty;
  assign pixel_data  = fifo_empty ? '0 : fifo_head;

  sync_fifo #(
    .WIDTH (RAM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (fifo_push),
    .push_data (ram_data),
    .pop       (fifo_pop),
    .flush     (!stream_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= ST_IDLE;
      ram_addr        <= '0;
      ram_read_enable <= 1'b0;
      lat_sr          <= '0;
      in_flight       <= '0;
      rd_cnt          <= '0;
      xfer_cnt        <= '0;
      pending         <= 1'b0;
      slice_index     <= '0;
      slice_done      <= 1'b0;
      underrun        <= 1'b0;
    end else if (!stream_ready) begin
      // Capture side withdrew the RAM contents: abandon everything except the
      // sticky underrun record. Data still in the RAM pipeline is dropped
      // because its request bits are cleared here.
      state           <= ST_IDLE;
      ram_read_enable <= 1'b0;
      lat_sr          <= '0;
      in_flight       <= '0;
      rd_cnt          <= '0;
      xfer_cnt        <= '0;
      pending         <= 1'b0;
      slice_index     <= '0;
      slice_done      <= 1'b0;
    end else begin
      slice_done      <= 1'b0;
      ram_read_enable <= issue;

      lat_sr[0] <= ram_read_enable;
      for (int i = 1; i < LAT; i++) lat_sr[i] <= lat_sr[i-1];

      case ({issue, fifo_push})
        2'b10:   in_flight <= in_flight + CNT_ONE;
        2'b01:   in_flight <= in_flight - CNT_ONE;
        default: in_flight <= in_flight;
      endcase

      if (issue) begin
        ram_addr <= slice_base + RAM_ADDR_WIDTH'(rd_cnt);
        rd_cnt   <= rd_cnt + PIX_ONE;
      end
      if (fifo_pop) xfer_cnt <= xfer_cnt + PIX_ONE;

      if (new_slice && (state == ST_READ || state == ST_DRAIN)) begin
        underrun <= 1'b1;
        pending  <= 1'b1;
      end

      case (state)
        ST_IDLE: state <= ST_WAIT_SLICE;
        ST_WAIT_SLICE: begin
          if (new_slice) begin
            state    <= ST_READ;
            rd_cnt   <= '0;
            xfer_cnt <= '0;
          end
        end
        ST_READ: begin
          if (issue && rd_cnt == LAST_PIX) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_pop && xfer_cnt == LAST_PIX) begin
            slice_done  <= 1'b1;
            slice_index <= (slice_index == LAST_IDX) ? '0 : slice_index + IDX_ONE;
            rd_cnt      <= '0;
            xfer_cnt    <= '0;
            // A request arriving on this very edge is honoured like an
            // earlier one; both restart reading immediately.
            if (pending || new_slice) begin
              state   <= ST_READ;
              pending <= 1'b0;
            end else begin
              state <= ST_WAIT_SLICE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
